// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM state encoding and the
// default instruction-memory geometry as seen from the CPU's PC space.
package im_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } load_state_e;

    localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam int          IM_SIZE      = 4096;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Assembles four accepted stream bytes into one little-endian word; the word is
// presented combinationally alongside the fourth byte so the FSM can act on it.
module im_loader_byte_packer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  count_q, count_d;
    logic [23:0] shift_q, shift_d;

    // Earlier bytes shift down so byte 0 ends up in bits [7:0].
    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else if (byte_valid_i) begin
            count_d = count_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && (count_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/im_loader.sv
// Boot-image loader: takes LEN / data / CSUM words off a byte stream, writes the
// data words into instruction memory at PC byte addresses and checks the sum.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
    parameter int          IMSIZE    = IM_SIZE
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // One extra bit so an image of exactly IMSIZE words does not wrap idx.
    localparam int IDXW = $clog2(IMSIZE) + 1;

    load_state_e     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] len_q, len_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            done_q, error_q;

    logic            xfer;
    logic            word_valid;
    logic [31:0]     word;

    assign in_ready_o = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign busy_o     = in_ready_o;
    assign xfer       = in_valid_i && in_ready_o;

    im_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (state_d != state_q),
        .byte_valid_i (xfer),
        .byte_i       (in_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d = LEN;
                    idx_d   = '0;
                    sum_d   = 32'd0;
                end
            end
            LEN: begin
                if (word_valid) begin
                    len_d = word[IDXW-1:0];
                    if (word > 32'(IMSIZE))
                        state_d = ERR;
                    else if (word == 32'd0)
                        state_d = CSUM;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                // Write strobe, address and sum all register on the same edge.
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                    wdata_d = word;
                    idx_d   = idx_q + IDXW'(1);
                    sum_d   = sum_q + word;
                    if ((idx_q + IDXW'(1)) == len_q)
                        state_d = CSUM;
                end
            end
            CSUM: begin
                if (word_valid)
                    state_d = (word == sum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            sum_q   <= 32'd0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= (state_d == DONE);
            error_q <= (state_d == ERR);
        end
    end

    assign im_we_o    = we_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = wdata_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: streams directed and random boot images and
// compares every IM write and the final status against an image-level model.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        inValid;
    logic [7:0]  inData;
    logic        inReady;
    logic        imWe;
    logic [31:0] imAddr;
    logic [31:0] imWdata;
    logic        busy;
    logic        done;
    logic        error;

    int          checks   = 0;
    int          passed   = 0;
    int          readyBad = 0;
    int          gapMode  = 0;
    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    logic [31:0] imgWords[$];

    always #5 clk = ~clk;

    im_loader dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .in_valid_i (inValid),
        .in_data_i  (inData),
        .in_ready_o (inReady),
        .im_we_o    (imWe),
        .im_addr_o  (imAddr),
        .im_wdata_o (imWdata),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    // Record every IM write and watch that in_ready tracks the loading phase.
    always @(negedge clk) begin
        if (imWe === 1'b1) begin
            gotAddr.push_back(imAddr);
            gotData.push_back(imWdata);
        end
        if (busy !== inReady)
            readyBad++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".inReady"}, 32'(inReady), 32'd0);
        checkOutput({tag, ".imWe"},    32'(imWe),    32'd0);
        checkOutput({tag, ".busy"},    32'(busy),    32'd0);
        checkOutput({tag, ".done"},    32'(done),    32'd0);
        checkOutput({tag, ".error"},   32'(error),   32'd0);
        checkOutput({tag, ".imAddr"},  imAddr,       32'h0000_3000);
        checkOutput({tag, ".imWdata"}, imWdata,      32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic sendByte(input logic [7:0] b);
        int waitCycles = 0;
        inValid = 1'b1;
        inData  = b;
        start   = (gapMode == 2) && ($urandom_range(0, 7) == 0);
        while (!inReady && waitCycles < 50) begin
            @(negedge clk);
            start = 1'b0;
            waitCycles++;
        end
        if (!inReady)
            checkOutput("byteAccept", 32'(inReady), 32'd1);
        @(negedge clk);
        start   = 1'b0;
        inValid = 1'b0;
        if (gapMode == 1)
            @(negedge clk);
        else if (gapMode == 2)
            repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            sendByte(w[8*i +: 8]);
    endtask

    task automatic pulseStart(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, ".startBusy"},  32'(busy),  32'd1);
        checkOutput({tag, ".startDone"},  32'(done),  32'd0);
        checkOutput({tag, ".startError"}, 32'(error), 32'd0);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, ".busyFalls"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Stream one image (LEN, imgWords[0..N-1], CSUM) and compare with the model.
    task automatic applyStimulus(input logic [31:0] lenWord, input logic [31:0] csumWord,
                                 input string tag);
        logic [31:0] sum = 32'd0;
        bit          lenOk;
        bit          expDone;
        int          expWrites;
        gotAddr.delete();
        gotData.delete();
        pulseStart(tag);
        sendWord(lenWord);
        lenOk = (lenWord <= 32'd4096);
        if (lenOk) begin
            for (int i = 0; i < int'(lenWord); i++)
                sendWord(imgWords[i]);
            sendWord(csumWord);
        end else begin
            checkOutput({tag, ".lenError"}, 32'(error),   32'd1);
            checkOutput({tag, ".lenReady"}, 32'(inReady), 32'd0);
        end
        waitIdle(tag);
        expWrites = lenOk ? int'(lenWord) : 0;
        for (int i = 0; i < expWrites; i++)
            sum += imgWords[i];
        expDone = lenOk && (csumWord == sum);
        checkOutput({tag, ".writes"}, 32'(gotAddr.size()), 32'(expWrites));
        for (int i = 0; i < expWrites && i < gotAddr.size(); i++) begin
            checkOutput({tag, ".addr"}, gotAddr[i], 32'h0000_3000 + 32'(4 * i));
            checkOutput({tag, ".data"}, gotData[i], imgWords[i]);
        end
        checkOutput({tag, ".done"},    32'(done),    32'(expDone));
        checkOutput({tag, ".error"},   32'(error),   32'(!expDone));
        checkOutput({tag, ".inReady"}, 32'(inReady), 32'd0);
    endtask

    initial begin
        logic [31:0] rsum;
        int          n;

        reset   = 1'b1;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = 8'd0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed image, back-to-back bytes");
        imgWords = '{32'h3C08_0001, 32'h2108_0004};
        applyStimulus(32'd2, 32'h5D10_0005, "basic");

        $display("[TB] directed image, in_valid toggling");
        gapMode = 1;
        applyStimulus(32'd2, 32'h5D10_0005, "toggle");
        checkOutput("toggle.readyTracksBusy", 32'(readyBad), 32'd0);
        gapMode = 0;

        $display("[TB] empty images and oversize length");
        imgWords.delete();
        applyStimulus(32'd0, 32'd0, "emptyOk");
        applyStimulus(32'd0, 32'd1, "emptyBad");
        applyStimulus(32'd4097, 32'd0, "tooLong");

        $display("[TB] checksum off by one");
        imgWords = '{32'h3C08_0001, 32'h2108_0004};
        applyStimulus(32'd2, 32'h5D10_0006, "badSum");

        $display("[TB] reset in the middle of DATA");
        gotAddr.delete();
        gotData.delete();
        imgWords = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        pulseStart("abort");
        sendWord(32'd4);
        sendWord(imgWords[0]);
        sendByte(8'hAB);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("abort");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort.writes", 32'(gotAddr.size()), 32'd1);
        if (gotAddr.size() > 0)
            checkOutput("abort.addr", gotAddr[0], 32'h0000_3000);
        applyStimulus(32'd4, 32'h1111_2222 + 32'h3333_4444 + 32'h5555_6666 + 32'h7777_8888,
                      "reload");

        $display("[TB] random images with random gaps and stray starts");
        gapMode = 2;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 8);
            imgWords.delete();
            rsum = 32'd0;
            for (int i = 0; i < n; i++) begin
                imgWords.push_back($urandom());
                rsum += imgWords[i];
            end
            if ($urandom_range(0, 3) == 0)
                rsum += 32'($urandom_range(1, 255));
            applyStimulus(32'(n), rsum, "random");
        end
        checkOutput("readyTracksBusy", 32'(readyBad), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
